// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request, response and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o, req0_we_i, req1_we_i;
  logic [2:0] req0_funct3_i, req1_funct3_i;
  logic [ADDR_W-1:0] req0_addr_i, req1_addr_i, mem_addr_o;
  logic [DATA_W-1:0] req0_wdata_i, req1_wdata_i, rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic rsp0_valid_o, rsp1_valid_o, rsp_err_o, mem_wr_en_o;
  modport slave (
    input req0_valid_i, req1_valid_i, req0_we_i, req1_we_i, req0_funct3_i, req1_funct3_i,
    input req0_addr_i, req1_addr_i, req0_wdata_i, req1_wdata_i, mem_rdata_i,
    output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_wr_en_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output req0_valid_i, req1_valid_i, req0_we_i, req1_we_i, req0_funct3_i, req1_funct3_i,
    output req0_addr_i, req1_addr_i, req0_wdata_i, req1_wdata_i, mem_rdata_i,
    input req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp_rdata_o, rsp_err_o,
    input mem_wr_en_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port RV32I load/store controller in front of a word-wide data memory
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic clk_i,
  input logic rst_i,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, LDCAP, WR, RMWWR, ERR} state_t;
  state_t state_q, state_d;
  logic owner_q, we_q, last_q, wr_q, rsp0_q, rsp1_q, err_q;
  logic [2:0] f3_q, f3_d;
  logic [1:0] lane_q;
  logic [ADDR_W-1:0] mem_addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, rdata_q, wdata_d, rd, ld_d, merged;
  logic idle, gnt0, gnt1, gnt, we_d, bad, done;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [4:0] sh;
  assign idle = state_q == IDLE && !rst_i;
  assign gnt0 = idle && bus.req0_valid_i && (!bus.req1_valid_i || last_q);
  assign gnt1 = idle && bus.req1_valid_i && (!bus.req0_valid_i || !last_q);
  assign gnt = gnt0 || gnt1;
  assign we_d = gnt1 ? bus.req1_we_i : bus.req0_we_i;
  assign f3_d = gnt1 ? bus.req1_funct3_i : bus.req0_funct3_i;
  assign addr_d = gnt1 ? bus.req1_addr_i : bus.req0_addr_i;
  assign wdata_d = gnt1 ? bus.req1_wdata_i : bus.req0_wdata_i;
  assign bad = (we_d ? (f3_d[2] || f3_d[1:0] == 2'b11) : (f3_d == 3'b011 || f3_d[2:1] == 2'b11))
             || (f3_d[1:0] == 2'b01 && addr_d[0]) || (f3_d[1:0] == 2'b10 && addr_d[1:0] != 2'b00);
  assign state_d = state_q == IDLE ? (gnt ? (bad ? ERR : (we_d && f3_d[1]) ? WR : RD) : IDLE)
                 : state_q == RD ? (we_q ? RMWWR : LDCAP) : IDLE;
  assign done = state_q inside {LDCAP, WR, RMWWR, ERR};
  assign rd = bus.mem_rdata_i;
  assign sh = {lane_q, 3'b000};
  assign byte_v = lane_q[1] ? (lane_q[0] ? rd[31:24] : rd[23:16]) : (lane_q[0] ? rd[15:8] : rd[7:0]);
  assign half_v = lane_q[1] ? rd[31:16] : rd[15:0];
  assign ld_d = f3_q[1] ? rd
              : f3_q[0] ? {{16{!f3_q[2] && half_v[15]}}, half_v}
              : {{24{!f3_q[2] && byte_v[7]}}, byte_v};
  assign merged = f3_q[0] ? (lane_q[1] ? {wdata_q[15:0], rd[15:0]} : {rd[31:16], wdata_q[15:0]})
                : (rd & ~(32'hFF << sh)) | ({24'b0, wdata_q[7:0]} << sh);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      f3_q <= '0;
      lane_q <= '0;
      wdata_q <= '0;
      last_q <= 1'b1;
      wr_q <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= state_d == WR || state_d == RMWWR;
      rsp0_q <= done && !owner_q;
      rsp1_q <= done && owner_q;
      err_q <= state_q == ERR;
      rdata_q <= state_q == LDCAP ? ld_d : '0;
      if (gnt) begin
        owner_q <= gnt1;
        last_q <= gnt1;
        we_q <= we_d;
        f3_q <= f3_d;
        lane_q <= addr_d[1:0];
        wdata_q <= wdata_d;
        if (!bad) mem_addr_q <= {addr_d[ADDR_W-1:2], 2'b00};
      end
    end
  end
  assign bus.req0_ready_o = gnt0;
  assign bus.req1_ready_o = gnt1;
  assign bus.rsp0_valid_o = rsp0_q;
  assign bus.rsp1_valid_o = rsp1_q;
  assign bus.rsp_err_o = err_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.mem_wr_en_o = wr_q && !rst_i;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_wdata_o = state_q == RMWWR ? merged : wdata_q;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbitrating controller in front of the 32-bit word-wide `dataMemory`. It accepts RV32I load/store requests from the core LSU (port 0) and the debug/program loader (port 1), and grants them round-robin. It performs byte/halfword loads with sign/zero extension and sub-word stores by read-modify-write. It also flags misaligned or illegal accesses without touching memory.

## Interface
- `ADDR_W`, 12: byte address width (matches `dataMemory.addr_i`).
- `DATA_W`, 32: data width; only 32 is supported.
- `clk_i` input 1: clock; all logic on rising edge.
- `rst_i` input 1: reset. One clock; reset is synchronous and active-high.
- `req0_valid_i`/`req1_valid_i` input 1: request valid, port 0/1.
- `req0_ready_o`/`req1_ready_o` output 1: request accepted this cycle.
- `req0_we_i`/`req1_we_i` input 1: 1 = store, 0 = load.
- `req0_funct3_i`/`req1_funct3_i` input 3: RV32I funct3 (size/sign).
- `req0_addr_i`/`req1_addr_i` input ADDR_W: byte address.
- `req0_wdata_i`/`req1_wdata_i` input 32: store data, right-aligned.
- `rsp0_valid_o`/`rsp1_valid_o` output 1: one-cycle completion pulse.
- `rsp_rdata_o` output 32: load result, shared; valid with either rsp pulse.
- `rsp_err_o` output 1: access error, shared; valid with either rsp pulse.
- `mem_wr_en_o` output 1: to `dataMemory.wr_en`.
- `mem_addr_o` output ADDR_W: to `dataMemory.addr_i`; always `{addr[11:2],2'b00}`.
- `mem_wdata_o` output 32: to `dataMemory.data_i`.
- `mem_rdata_i` input 32: from `dataMemory.data_o`. Word addressed in cycle N is valid in cycle N+1.

## Operation
- States: IDLE, RD, LDCAP, WR, RMWWR, ERR.
- IDLE: `reqX_ready_o` is combinational. It is high only in IDLE, only for the arbitration winner, and only while that port's valid is high. On the handshake edge, capture owner, we, funct3, addr and wdata.
- Arbitration: with a single valid, that port wins. With both valid, the port not granted last wins. After reset, port 0 wins the first tie.
- Legality checks:
  - Loads: funct3 000/001/010/100/101 are legal. Stores: 000/001/010 are legal. Anything else is an error.
  - Half accesses need `addr[0]=0`. Word accesses need `addr[1:0]=00`.
  - An illegal or misaligned access goes to ERR and never drives `mem_wr_en_o`.
- Next state from IDLE:
  - Load: RD.
  - Word store: WR.
  - Byte or half store: RD (the read phase of the read-modify-write).
- RD: drive `mem_addr_o`, `mem_wr_en_o=0`. Next state is LDCAP for a load, RMWWR for a sub-word store.
- LDCAP: select the byte/half lane using `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into `rsp_rdata_o`, then go to IDLE.
- WR: `mem_wr_en_o=1`, `mem_wdata_o=wdata`, then go to IDLE.
- RMWWR:
  - `mem_wr_en_o=1`.
  - `mem_wdata_o` is `mem_rdata_i` with the selected lane replaced by `wdata[7:0]` (SB) or `wdata[15:0]` (SH).
  - Next state is IDLE.
- ERR: no memory activity, next state IDLE.
- Response: `rspX_valid_o` (X = owner) pulses high for exactly one cycle, in the cycle after LDCAP/WR/RMWWR/ERR.
  - That cycle is IDLE, so a new request can be accepted in the same cycle.
  - `rsp_err_o=1` only for ERR completions.
  - `rsp_rdata_o` is 0 for stores and errors.

## Timing
- Take the handshake cycle as cycle 0. `rspX_valid_o` fires in:
  - cycle 2: word store, error;
  - cycle 3: load, sub-word store.
- Write commits at the rising edge ending WR/RMWWR.
- Back-to-back throughput: the next accept can coincide with the response cycle.
- Outside RD/WR/RMWWR: `mem_wr_en_o=0`, `mem_addr_o` holds its last value, `mem_wdata_o` is don't-care.
- Reset values: state IDLE; all ready/rsp_valid/rsp_err/mem_wr_en = 0; `rsp_rdata_o`, `mem_addr_o`, `mem_wdata_o` = 0; tie priority = port 0.
- Reset asserted mid-operation:
  - `mem_wr_en_o` is gated low in that same cycle, so no write commits.
  - The in-flight request is dropped with no response.
- Request signals must stay stable while valid is high and ready is low. The requester may drop valid before it is granted; no state is retained.

## Test plan
- Port 0 SW addr 0x004 data 9, then LW 0x004 → store rsp at cycle 2, err 0. Load rsp at cycle 3 with rdata 0x00000009.
- Memory word 0x008 = 0x11223344. SB addr 0x009 data 0xAB, then LW 0x008 → 0x1122AB44. LB 0x009 → 0xFFFFFFAB. LBU 0x009 → 0x000000AB.
- Memory word 0x00C = 0x80017FFF. LH 0x00E → 0xFFFF8001. LHU 0x00C → 0x00007FFF. SH 0x00E data 0x1234 → word reads 0x12347FFF.
- Misaligned LW 0x002, SH 0x001 and a store with funct3 100 → each gives rsp err=1 at cycle 2, rdata 0, `mem_wr_en_o` never high.
- Both ports hold valid continuously, issuing SW to 0x000 and 0x010 → grants alternate 0,1,0,1 starting with port 0. Each rsp goes only to the owner. No lost or duplicated writes.
- `rst_i` pulses during the WR cycle of SW 0x004 data 150 → `mem_wr_en_o` stays 0, no rsp, a subsequent LW 0x004 returns the previous value, and all outputs read their reset values the cycle after reset.
